// File: rtl/multicycle_control.sv
// Multicycle LEGv8 controller: sequences fetch/decode/execute/memory/writeback on a shared
// datapath, one instruction at a time, counting retirements and halting on unknown opcodes.
module multicycle_control #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             imem_valid,
  input  logic             dmem_ready,
  input  logic             zero_E,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic             Reg2Loc,
  output logic             AluSrc,
  output logic [3:0]       AluControl,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             MemtoReg,
  output logic [2:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    ClsAdd,
    ClsSub,
    ClsAnd,
    ClsOrr,
    ClsLdur,
    ClsStur,
    ClsCbz,
    ClsIll
  } cls_e;

  localparam logic [10:0] OpAdd  = 11'h458;
  localparam logic [10:0] OpSub  = 11'h658;
  localparam logic [10:0] OpAnd  = 11'h450;
  localparam logic [10:0] OpOrr  = 11'h550;
  localparam logic [10:0] OpLdur = 11'h7C2;
  localparam logic [10:0] OpStur = 11'h7C0;
  localparam logic [7:0]  OpCbz  = 8'hB4;

  state_e           state_q, state_d;
  logic [10:0]      op_q, op_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ready_q;
  cls_e             cls;
  logic             fetch_go;
  logic             in_flight;

  // Operand/immediate fields are consumed by the datapath, not here.
  logic unused_instr_low;
  assign unused_instr_low = ^instr[20:0];

  always_comb begin
    cls = ClsIll;
    if (op_q[10:3] == OpCbz) begin
      cls = ClsCbz;
    end else begin
      case (op_q)
        OpAdd:   cls = ClsAdd;
        OpSub:   cls = ClsSub;
        OpAnd:   cls = ClsAnd;
        OpOrr:   cls = ClsOrr;
        OpLdur:  cls = ClsLdur;
        OpStur:  cls = ClsStur;
        default: cls = ClsIll;
      endcase
    end
  end

  // ready_q keeps the first cycle after reset release free of any fetch handshake.
  assign fetch_go  = ready_q & imem_valid;
  assign in_flight = (state_q == StDecode) || (state_q == StExec) ||
                     (state_q == StMem)    || (state_q == StWb);

  always_comb begin
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    PCSrc      = 1'b0;
    Reg2Loc    = 1'b0;
    AluSrc     = 1'b0;
    AluControl = 4'b0000;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    MemtoReg   = 1'b0;

    if (in_flight) begin
      case (cls)
        ClsAdd:  AluControl = 4'b0010;
        ClsSub:  AluControl = 4'b0110;
        ClsAnd:  AluControl = 4'b0000;
        ClsOrr:  AluControl = 4'b0001;
        ClsLdur: begin
          AluSrc     = 1'b1;
          AluControl = 4'b0010;
          MemtoReg   = 1'b1;
        end
        ClsStur: begin
          AluSrc     = 1'b1;
          AluControl = 4'b0010;
          Reg2Loc    = 1'b1;
        end
        ClsCbz: begin
          AluControl = 4'b0111;
          Reg2Loc    = 1'b1;
        end
        default: ;
      endcase
    end

    case (state_q)
      StFetch: IRWrite = fetch_go;
      StExec: begin
        if (cls == ClsCbz) begin
          PCWrite = 1'b1;
          PCSrc   = zero_E;
        end
      end
      StMem: begin
        MemRead  = (cls == ClsLdur);
        MemWrite = (cls == ClsStur);
        PCWrite  = (cls == ClsStur) & dmem_ready;
      end
      StWb: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = illegal_q;
    count_d   = count_q + CNT_W'(PCWrite);

    case (state_q)
      StFetch: begin
        if (fetch_go) begin
          op_d    = instr[31:21];
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (cls == ClsIll) begin
          state_d   = StHalt;
          illegal_d = 1'b1;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        case (cls)
          ClsAdd, ClsSub, ClsAnd, ClsOrr: state_d = StWb;
          ClsLdur, ClsStur:               state_d = StMem;
          ClsCbz:                         state_d = StFetch;
          default:                        state_d = StHalt;
        endcase
      end
      StMem: begin
        if (dmem_ready) begin
          state_d = (cls == ClsLdur) ? StWb : StFetch;
        end
      end
      StWb:    state_d = StFetch;
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StFetch;
      op_q      <= '0;
      illegal_q <= 1'b0;
      count_q   <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
      ready_q   <= 1'b1;
    end
  end

  assign state       = state_q;
  assign illegal     = illegal_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: table-driven instruction-route model checked every cycle,
// directed cases from the instruction set, then randomized traffic with random resets.
module tb_multicycle_control;

  localparam int unsigned CntW = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [31:0]     instr = '0;
  logic            imem_valid = 1'b0;
  logic            dmem_ready = 1'b0;
  logic            zero_E = 1'b0;
  logic            IRWrite, PCWrite, PCSrc, Reg2Loc, AluSrc;
  logic [3:0]      AluControl;
  logic            MemRead, MemWrite, RegWrite, MemtoReg;
  logic [2:0]      state;
  logic            illegal;
  logic [CntW-1:0] instr_count;

  multicycle_control #(.CNT_W(CntW)) dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .imem_valid (imem_valid),
    .dmem_ready (dmem_ready),
    .zero_E     (zero_E),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .PCSrc      (PCSrc),
    .Reg2Loc    (Reg2Loc),
    .AluSrc     (AluSrc),
    .AluControl (AluControl),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .MemtoReg   (MemtoReg),
    .state      (state),
    .illegal    (illegal),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Classes: 0 ADD, 1 SUB, 2 AND, 3 ORR, 4 LDUR, 5 STUR, 6 CBZ, 7 illegal.
  // Each class walks a fixed list of phases after the fetch cycle (1 DEC, 2 EX, 3 MEM, 4 WB, 5 HALT).
  int route [8][4] = '{'{1, 2, 4, 0}, '{1, 2, 4, 0}, '{1, 2, 4, 0}, '{1, 2, 4, 0},
                       '{1, 2, 3, 4}, '{1, 2, 3, 0}, '{1, 2, 0, 0}, '{1, 5, 0, 0}};
  int route_len [8] = '{3, 3, 3, 3, 4, 3, 2, 2};
  int alu_ctl   [8] = '{2, 6, 0, 1, 2, 2, 7, 0};
  bit alu_src   [8] = '{0, 0, 0, 0, 1, 1, 0, 0};
  bit reg2loc   [8] = '{0, 0, 0, 0, 0, 1, 1, 0};
  bit mem2reg   [8] = '{0, 0, 0, 0, 1, 0, 0, 0};

  int m_phase, m_cls, m_step, m_count;
  bit m_illegal, m_fresh;

  logic       e_irw, e_pcw, e_pcsrc, e_r2l, e_alusrc, e_mr, e_mw, e_rw, e_m2r;
  logic [3:0] e_aluc;

  logic       obs_irw, obs_mw, f_irw;
  logic       exec_pcw, exec_pcsrc, exec_r2l, exec_alusrc;
  logic [3:0] exec_aluc;
  logic       wb_rw, wb_m2r, wb_pcw;
  int         n_mr, lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int classify(input logic [10:0] op);
    if (op[10:3] == 8'hB4) return 6;
    case (op)
      11'h458: return 0;
      11'h658: return 1;
      11'h450: return 2;
      11'h550: return 3;
      11'h7C2: return 4;
      11'h7C0: return 5;
      default: return 7;
    endcase
  endfunction

  task automatic model_reset();
    m_phase   = 0;
    m_cls     = 0;
    m_step    = 0;
    m_count   = 0;
    m_illegal = 0;
    m_fresh   = 1;
  endtask

  task automatic model_eval(input logic iv, input logic dr, input logic z);
    bit busy;
    busy = (m_phase >= 1) && (m_phase <= 4);
    {e_irw, e_pcw, e_pcsrc, e_r2l, e_alusrc, e_mr, e_mw, e_rw, e_m2r} = '0;
    e_aluc = 4'd0;
    e_irw  = (m_phase == 0) && !m_fresh && iv;
    if (busy) begin
      e_alusrc = alu_src[m_cls];
      e_aluc   = 4'(alu_ctl[m_cls]);
      e_r2l    = reg2loc[m_cls];
      e_m2r    = mem2reg[m_cls];
    end
    if (m_phase == 2 && m_cls == 6) begin
      e_pcw   = 1'b1;
      e_pcsrc = z;
    end
    if (m_phase == 3) begin
      e_mr  = (m_cls == 4);
      e_mw  = (m_cls == 5);
      e_pcw = (m_cls == 5) && dr;
    end
    if (m_phase == 4) begin
      e_rw  = 1'b1;
      e_pcw = 1'b1;
    end
  endtask

  task automatic model_step(input logic iv, input logic [31:0] ins, input logic dr);
    if (e_pcw) m_count = (m_count + 1) % (1 << CntW);
    if (m_phase == 0) begin
      if (!m_fresh && iv) begin
        m_cls   = classify(ins[31:21]);
        m_step  = 0;
        m_phase = route[m_cls][0];
      end
    end else if (m_phase == 5 || (m_phase == 3 && !dr)) begin
      // halted, or memory still busy
    end else begin
      if (m_phase == 1 && m_cls == 7) m_illegal = 1;
      m_step++;
      m_phase = (m_step < route_len[m_cls]) ? route[m_cls][m_step] : 0;
    end
    m_fresh = 0;
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic cycle(input logic iv, input logic [31:0] ins, input logic dr, input logic z);
    imem_valid = iv;
    instr      = ins;
    dmem_ready = dr;
    zero_E     = z;
    #1;
    model_eval(iv, dr, z);
    chk("IRWrite", IRWrite, e_irw);
    chk("PCWrite", PCWrite, e_pcw);
    chk("PCSrc", PCSrc, e_pcsrc);
    chk("Reg2Loc", Reg2Loc, e_r2l);
    chk("AluSrc", AluSrc, e_alusrc);
    chk("AluControl", AluControl, e_aluc);
    chk("MemRead", MemRead, e_mr);
    chk("MemWrite", MemWrite, e_mw);
    chk("RegWrite", RegWrite, e_rw);
    chk("MemtoReg", MemtoReg, e_m2r);
    chk("state", state, m_phase);
    chk("illegal", illegal, m_illegal);
    chk("instr_count", instr_count, m_count);
    obs_irw = IRWrite;
    obs_mw  = MemWrite;
    if (MemRead) n_mr++;
    if (m_phase == 0) f_irw = IRWrite;
    if (m_phase == 2) begin
      exec_pcw    = PCWrite;
      exec_pcsrc  = PCSrc;
      exec_r2l    = Reg2Loc;
      exec_alusrc = AluSrc;
      exec_aluc   = AluControl;
    end
    if (m_phase == 4) begin
      wb_rw  = RegWrite;
      wb_m2r = MemtoReg;
      wb_pcw = PCWrite;
    end
    @(posedge clk);
    model_step(iv, ins, dr);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    chk({tag, "_rst_state"}, state, 0);
    chk({tag, "_rst_ctrl"}, {IRWrite, PCWrite, PCSrc, Reg2Loc, AluSrc, AluControl,
                             MemRead, MemWrite, RegWrite, MemtoReg}, 0);
    chk({tag, "_rst_illegal"}, illegal, 0);
    chk({tag, "_rst_count"}, instr_count, 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Issue one instruction from FETCH and run it to the next FETCH (or HALT).
  task automatic instr_seq(input logic [31:0] ins, input logic z, input int waits);
    int   w;
    int   guard;
    logic dr;
    w     = 0;
    guard = 0;
    n_mr  = 0;
    lat   = 1;
    cycle(1'b1, ins, 1'b0, z);
    while (m_phase != 0 && m_phase != 5 && guard < 40) begin
      dr = (m_phase == 3) && (w >= waits);
      if (m_phase == 3) w++;
      cycle(1'b0, $urandom, dr, z);
      lat++;
      guard++;
    end
    chk("seq_completes", guard < 40, 1);
  endtask

  function automatic logic [31:0] rand_instr();
    int          k;
    logic [10:0] op;
    k = $urandom_range(0, 24);
    if (k < 18) begin
      case (k % 6)
        0:       op = 11'h458;
        1:       op = 11'h658;
        2:       op = 11'h450;
        3:       op = 11'h550;
        4:       op = 11'h7C2;
        default: op = 11'h7C0;
      endcase
    end else if (k < 23) begin
      op = {8'hB4, 3'($urandom)};
    end else begin
      op = (k == 23) ? 11'h000 : 11'h7FF;
    end
    return {op, 21'($urandom)};
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected the run to finish");
    $fatal(1);
  end

  initial begin
    #2;
    do_reset("por");

    // Fetch offered in the first cycle after release must be ignored.
    cycle(1'b1, 32'h8B0202A1, 1'b0, 1'b0);
    chk("first_cycle_irw", obs_irw, 0);

    instr_seq(32'h8B0202A1, 1'b0, 0);
    chk("add_irwrite", f_irw, 1);
    chk("add_aluc", exec_aluc, 4'b0010);
    chk("add_alusrc", exec_alusrc, 0);
    chk("add_regwrite", wb_rw, 1);
    chk("add_pcwrite", wb_pcw, 1);
    chk("add_latency", lat, 4);
    chk("add_count", instr_count, 1);

    instr_seq({11'h7C2, 21'h0A1B2}, 1'b0, 3);
    chk("ldur_memread_cycles", n_mr, 4);
    chk("ldur_latency", lat, 8);
    chk("ldur_alusrc", exec_alusrc, 1);
    chk("ldur_aluc", exec_aluc, 4'b0010);
    chk("ldur_wb_regwrite", wb_rw, 1);
    chk("ldur_wb_memtoreg", wb_m2r, 1);
    chk("ldur_count", instr_count, 2);

    instr_seq({8'hB4, 24'h000123}, 1'b1, 0);
    chk("cbz1_pcwrite", exec_pcw, 1);
    chk("cbz1_pcsrc", exec_pcsrc, 1);
    chk("cbz1_aluc", exec_aluc, 4'b0111);
    chk("cbz1_reg2loc", exec_r2l, 1);
    chk("cbz1_latency", lat, 3);

    instr_seq({8'hB4, 3'b101, 21'h7}, 1'b0, 0);
    chk("cbz0_pcwrite", exec_pcw, 1);
    chk("cbz0_pcsrc", exec_pcsrc, 0);
    chk("cbz0_latency", lat, 3);
    chk("cbz0_count", instr_count, 4);

    instr_seq(32'h0000_1234, 1'b0, 0);
    chk("ill_state", state, 5);
    chk("ill_flag", illegal, 1);
    repeat (4) begin
      cycle(1'b1, {11'h458, 21'h0}, 1'b1, 1'b1);
      cycle(1'b0, 32'h0, 1'b0, 1'b0);
    end
    chk("ill_count_frozen", instr_count, 4);
    do_reset("ill");

    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) instr_seq({11'h550, 21'(i)}, 1'b0, 0);
    chk("orr_aluc", exec_aluc, 4'b0001);
    chk("wrap_15", instr_count, 15);
    instr_seq({11'h550, 21'h1F}, 1'b0, 0);
    chk("wrap_0", instr_count, 0);

    instr_seq(32'h8B0202A1, 1'b0, 0);
    cycle(1'b1, {11'h7C0, 21'h3}, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("stur_memwrite", obs_mw, 1);
    chk("stur_in_mem", state, 3);
    chk("stur_count_before", instr_count, 1);
    do_reset("stur");

    for (int i = 0; i < 2500; i++) begin
      if (m_phase == 5 && $urandom_range(0, 5) == 0) begin
        do_reset("rnd_halt");
      end else if ($urandom_range(0, 399) == 0) begin
        do_reset("rnd");
      end else begin
        cycle($urandom_range(0, 3) != 0, rand_instr(), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
